// File: rtl/noc_inject_arbiter.sv
// NoC injection-port arbiter: round-robin, packet-locked sharing of one router
// injection port among NUM_REQ requesters, with credit-based flow control.
module noc_inject_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned DEST_WIDTH        = 4,
    parameter int unsigned FLIT_WIDTH        = 256,
    parameter int unsigned FLIT_BUFFER_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] req_data [NUM_REQ],
    input  logic [DEST_WIDTH-1:0] req_dest [NUM_REQ],
    input  logic [NUM_REQ-1:0]    req_is_tail,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic                  credit_overflow
);

    localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CredW = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CredW-1:0] CredMax = CredW'(FLIT_BUFFER_DEPTH);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [CredW-1:0]      credits_q, credits_d;
    logic                  overflow_q, overflow_d;

    logic                  winner_found;
    logic [IdxW-1:0]       winner_idx;
    logic [IdxW-1:0]       cand_idx;
    logic [IdxW-1:0]       grant_idx;
    logic [NUM_REQ-1:0]    ready_int;
    logic                  accept;
    logic                  grant_tail;

    // Wrapping increment of a requester index.
    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        logic [IdxW-1:0] res;
        if (32'(idx) == NUM_REQ - 1) begin
            res = '0;
        end else begin
            res = idx + IdxW'(1);
        end
        return res;
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = rr_ptr_q;
        cand_idx     = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_idx = IdxW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!winner_found && req_valid[cand_idx]) begin
                winner_found = 1'b1;
                winner_idx   = cand_idx;
            end
        end
    end

    // Grant selection, ready generation and FSM next state.
    always_comb begin
        ready_int = '0;
        grant_idx = winner_idx;
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        unique case (state_q)
            StIdle: begin
                grant_idx = winner_idx;
                if (credits_q != '0 && winner_found) begin
                    ready_int[winner_idx] = 1'b1;
                end
            end
            StLocked: begin
                // Port stays with the owner until its tail; others are ignored.
                grant_idx = owner_q;
                if (credits_q != '0) begin
                    ready_int[owner_q] = 1'b1;
                end
            end
        endcase
        accept     = |(ready_int & req_valid);
        grant_tail = req_is_tail[grant_idx];
        if (accept) begin
            if (grant_tail) begin
                state_d  = StIdle;
                rr_ptr_d = next_idx(grant_idx);
            end else begin
                state_d = StLocked;
                owner_d = grant_idx;
            end
        end
    end

    // Credit accounting; a surplus credit at full count saturates and flags an error.
    always_comb begin
        credits_d  = credits_q;
        overflow_d = overflow_q;
        if (accept && !credit_in) begin
            credits_d = credits_q - CredW'(1);
        end else if (credit_in && !accept) begin
            if (credits_q == CredMax) begin
                overflow_d = 1'b1;
            end else begin
                credits_d = credits_q + CredW'(1);
            end
        end
    end

    // Ready is forced low while reset is held.
    assign req_ready       = ready_int & {NUM_REQ{rst_n}};
    assign credit_overflow = overflow_q;

    // Arbitration and credit state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            credits_q  <= CredMax;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    // Output flit register: one-cycle latency, fields hold when nothing is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_out    <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
        end else begin
            send_out <= accept;
            if (accept) begin
                data_out    <= req_data[grant_idx];
                dest_out    <= req_dest[grant_idx];
                is_tail_out <= grant_tail;
            end
        end
    end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_noc_inject_arbiter;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int FW    = 256;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FW-1:0]     req_data [N];
    logic [DW-1:0]     req_dest [N];
    logic [N-1:0]      req_is_tail = '0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [FW-1:0]     data_out;
    logic [DW-1:0]     dest_out;
    logic              is_tail_out;
    logic              send_out;
    logic              credit_in = 1'b0;
    logic              credit_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    noc_inject_arbiter #(
        .NUM_REQ          (N),
        .DEST_WIDTH       (DW),
        .FLIT_WIDTH       (FW),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_data       (req_data),
        .req_dest       (req_dest),
        .req_is_tail    (req_is_tail),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .data_out       (data_out),
        .dest_out       (dest_out),
        .is_tail_out    (is_tail_out),
        .send_out       (send_out),
        .credit_in      (credit_in),
        .credit_overflow(credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Payloads change every cycle so a stale or wrong capture is visible.
    task automatic refresh_data();
        for (int r = 0; r < N; r++) begin
            req_data[r] = {32'hDEADBEEF, 200'(0), 8'(r), 16'(cyc)};
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        refresh_data();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        req_is_tail = '0;
        credit_in   = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model and per-cycle compare ----------------
    int            m_credits = DEPTH;
    bit            m_locked  = 1'b0;
    int            m_owner   = 0;
    int            m_rr      = 0;
    bit            m_ovf     = 1'b0;
    bit            m_send    = 1'b0;
    logic [FW-1:0] m_data    = '0;
    logic [DW-1:0] m_dest    = '0;
    bit            m_tail    = 1'b0;
    logic [N-1:0]  m_ready;
    int            m_best;
    int            m_acc;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_credits = DEPTH;
                m_locked  = 1'b0;
                m_owner   = 0;
                m_rr      = 0;
                m_ovf     = 1'b0;
                m_send    = 1'b0;
                m_data    = '0;
                m_dest    = '0;
                m_tail    = 1'b0;
            end
            // Expected ready: owner if locked, else the valid requester closest
            // to the round-robin pointer in wrap-around distance.
            m_ready = '0;
            if (rst_n && m_credits > 0) begin
                if (m_locked) begin
                    m_ready[m_owner] = 1'b1;
                end else begin
                    m_best = -1;
                    for (int r = 0; r < N; r++) begin
                        if (req_valid[r] && (m_best < 0 ||
                            ((r - m_rr + N) % N) < ((m_best - m_rr + N) % N))) begin
                            m_best = r;
                        end
                    end
                    if (m_best >= 0) m_ready[m_best] = 1'b1;
                end
            end
            check("model_ready", FW'(req_ready), FW'(m_ready));
            check("model_send", FW'(send_out), FW'(m_send));
            check("model_data", data_out, m_data);
            check("model_dest", FW'(dest_out), FW'(m_dest));
            check("model_tail", FW'(is_tail_out), FW'(m_tail));
            check("model_ovf", FW'(credit_overflow), FW'(m_ovf));
            if (rst_n) begin
                m_acc = -1;
                for (int r = 0; r < N; r++) begin
                    if (m_ready[r] && req_valid[r]) m_acc = r;
                end
                m_send = (m_acc >= 0);
                if (m_acc >= 0) begin
                    m_data = req_data[m_acc];
                    m_dest = req_dest[m_acc];
                    m_tail = req_is_tail[m_acc];
                    if (req_is_tail[m_acc]) begin
                        m_locked = 1'b0;
                        m_rr     = (m_acc + 1) % N;
                    end else begin
                        m_locked = 1'b1;
                        m_owner  = m_acc;
                    end
                end
                if (m_acc >= 0 && !credit_in) begin
                    m_credits--;
                end else if (credit_in && m_acc < 0) begin
                    if (m_credits == DEPTH) m_ovf = 1'b1;
                    else m_credits++;
                end
            end
        end
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    logic [N-1:0] t3_rdy [5];
    int           t3_dst [5];
    int           nsend;

    initial begin
        for (int r = 0; r < N; r++) req_dest[r] = '0;
        refresh_data();
        t3_rdy = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0000};
        t3_dst = '{0, 5, 5, 5, 9};

        // Reset state while held, including with a valid request present.
        req_valid = 4'b0001;
        #2;
        check("rst_send", FW'(send_out), FW'(0));
        check("rst_ready", FW'(req_ready), FW'(0));
        check("rst_data", data_out, FW'(0));
        check("rst_ovf", FW'(credit_overflow), FW'(0));
        do_reset();

        // Single-flit packet.
        req_valid      = 4'b0001;
        req_is_tail    = 4'b0001;
        req_dest[0]    = 4'd3;
        @(negedge clk);
        check("single_ready", FW'(req_ready), FW'(4'b0001));
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_send", FW'(send_out), FW'(1));
        check("single_dest", FW'(dest_out), FW'(3));
        check("single_tail", FW'(is_tail_out), FW'(1));
        step();
        step();

        // Round robin: all requesters offer single-flit packets, credit returned with each send.
        do_reset();
        for (int r = 0; r < N; r++) req_dest[r] = DW'(r);
        req_valid   = 4'b1111;
        req_is_tail = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 8) check("rr_ready", FW'(req_ready), FW'(4'b0001) << (k % 4));
            if (k > 0) begin
                check("rr_send", FW'(send_out), FW'(1));
                check("rr_dest", FW'(dest_out), FW'((k - 1) % 4));
            end
            step();
            if (k == 7) req_valid = '0;
            credit_in = send_out;
        end
        step();
        credit_in = 1'b0;

        // Packet lock: req1 three-flit packet while req2 waits.
        do_reset();
        req_dest[1] = 4'd5;
        req_dest[2] = 4'd9;
        req_valid   = 4'b0110;
        req_is_tail = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("lock_ready", FW'(req_ready), FW'(t3_rdy[c]));
            check("lock_send", FW'(send_out), FW'(c > 0));
            if (c > 0) check("lock_dest", FW'(dest_out), FW'(t3_dst[c]));
            step();
            credit_in = send_out;
            if (c == 1) req_is_tail[1] = 1'b1;
            if (c == 2) req_valid[1] = 1'b0;
            if (c == 3) req_valid = '0;
        end
        step();
        credit_in = 1'b0;

        // Credit stall: no credits returned until cycle 10.
        do_reset();
        req_dest[0] = 4'd2;
        req_valid   = 4'b0001;
        req_is_tail = 4'b0000;
        nsend = 0;
        for (int c = 0; c < 13; c++) begin
            credit_in = (c == 10);
            if (c == 11) req_is_tail[0] = 1'b1;
            if (c == 12) req_valid = '0;
            @(negedge clk);
            if (c <= 11 && send_out) nsend++;
            if (c >= 2 && c <= 10) check("stall_ready", FW'(req_ready), FW'(0));
            if (c == 11) check("stall_resume", FW'(req_ready), FW'(4'b0001));
            if (c == 12) begin
                check("stall_send", FW'(send_out), FW'(1));
                check("stall_tail", FW'(is_tail_out), FW'(1));
            end
            step();
        end
        check("stall_count", FW'(nsend), FW'(2));

        // Simultaneous accept and credit at credits==1, then overflow.
        do_reset();
        req_valid   = 4'b0001;
        req_is_tail = 4'b0001;
        @(negedge clk);
        check("sim_c0", FW'(req_ready), FW'(4'b0001));
        step();
        credit_in = 1'b1;
        @(negedge clk);
        check("sim_c1", FW'(req_ready), FW'(4'b0001));
        step();
        credit_in = 1'b0;
        @(negedge clk);
        check("sim_c2", FW'(req_ready), FW'(4'b0001));
        step();
        @(negedge clk);
        check("sim_c3_empty", FW'(req_ready), FW'(0));
        step();
        req_valid = '0;
        credit_in = 1'b1;
        step();
        step();
        @(negedge clk);
        check("ovf_before", FW'(credit_overflow), FW'(0));
        step();
        credit_in = 1'b0;
        @(negedge clk);
        check("ovf_set", FW'(credit_overflow), FW'(1));
        repeat (3) step();
        @(negedge clk);
        check("ovf_sticky", FW'(credit_overflow), FW'(1));

        // Reset while locked on req3.
        do_reset();
        req_dest[3] = 4'd7;
        req_valid   = 4'b1000;
        req_is_tail = 4'b0000;
        @(negedge clk);
        check("mid_c0", FW'(req_ready), FW'(4'b1000));
        step();
        credit_in = send_out;
        req_valid = 4'b1001;
        @(negedge clk);
        check("mid_locked", FW'(req_ready), FW'(4'b1000));
        step();
        credit_in = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_send", FW'(send_out), FW'(0));
        check("mid_rst_ready", FW'(req_ready), FW'(0));
        check("mid_rst_dest", FW'(dest_out), FW'(0));
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_after", FW'(req_ready), FW'(4'b0001));
        step();
        req_valid = '0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Shares one NoC endpoint injection port (data/dest/is_tail/send out, credit in) among NUM_REQ local requesters.
- Arbitration is round-robin at packet granularity: once a head flit is granted, the port is locked to that requester until its tail flit is accepted.
- Tracks downstream router input-buffer space with a credit counter, so no flit is ever sent without a free slot.
- Sits between endpoint logic and the corresponding router port-0 injection interface of a ring/double-ring NoC.

Parameters:
- NUM_REQ, 4, number of local requesters (>=2).
- DEST_WIDTH, 4, destination field width.
- FLIT_WIDTH, 256, flit payload width.
- FLIT_BUFFER_DEPTH, 2, downstream router input buffer depth; initial and maximum credit count.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_data  input  FLIT_WIDTH x [NUM_REQ]  per-requester flit payload.
- req_dest  input  DEST_WIDTH x [NUM_REQ]  per-requester destination.
- req_is_tail  input  1 x [NUM_REQ]  flit is last of packet (single-flit packet: head=tail).
- req_valid  input  1 x [NUM_REQ]  requester presents a flit.
- req_ready  output  1 x [NUM_REQ]  flit accepted this cycle when valid&&ready.
- data_out  output  FLIT_WIDTH  flit to router injection port.
- dest_out  output  DEST_WIDTH  destination to router.
- is_tail_out  output  1  tail marker to router.
- send_out  output  1  one-cycle pulse per flit sent.
- credit_in  input  1  one-cycle pulse; router freed one buffer slot.
- credit_overflow  output  1  sticky error flag.

Behaviour:
- Reset values (async on rst_n low):
  - send_out=0, data_out=0, dest_out=0, is_tail_out=0, credit_overflow=0.
  - credits=FLIT_BUFFER_DEPTH, state=IDLE, rr_ptr=0.
  - req_ready is all 0 while rst_n is low.
- Credit counter width: $clog2(FLIT_BUFFER_DEPTH+1).
  - Decrement on each accepted flit; increment on credit_in.
  - Both in the same cycle: net unchanged.
  - credit_in when credits==FLIT_BUFFER_DEPTH and no accept: count saturates and credit_overflow sets; it is sticky until reset.
- FSM state IDLE:
  - Winner = first requester with req_valid, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - If credits>0, req_ready[winner]=1 combinationally and the flit is accepted the same cycle.
  - If the accepted flit has is_tail=1: stay IDLE, rr_ptr<=winner+1 (wrapping).
  - Otherwise: go to LOCKED with owner<=winner.
  - If credits==0, no ready is asserted and rr_ptr is unchanged.
- FSM state LOCKED:
  - req_ready[owner]=(credits>0); all other ready signals are 0.
  - Other requesters' valids are ignored.
  - Accepted tail: go to IDLE, rr_ptr<=owner+1 (wrapping).
  - The owner may drop valid mid-packet; the arbiter waits in LOCKED indefinitely (no timeout).
- Output register:
  - An accepted flit appears on data_out/dest_out/is_tail_out with send_out=1 the next cycle (latency 1).
  - send_out=0 in any cycle following no accept; data fields hold their last value.
- Throughput: one flit per cycle when credits allow. Back-to-back packets from different requesters have zero bubble (tail accept in IDLE/LOCKED, then new head the next cycle).
- req_ready depends only on state, rr_ptr, owner, credits and req_valid, with no other combinational input-to-output path. It must not depend on credit_in in the same cycle: a credit takes effect the cycle after it arrives.

Test Plan:
- Single-flit packet: NUM_REQ=4, DEPTH=2, req0 valid with tail, dest=3 → req_ready[0]=1 in cycle 0; send_out=1, dest_out=3, is_tail_out=1 in cycle 1; credits go 2→1.
- Round-robin fairness: all 4 requesters continuously offer single-flit packets, credit_in returned one cycle after each send_out → grant order 0,1,2,3,0,…, one send per cycle.
- Packet lock: req1 sends a 3-flit packet while req2 is valid throughout → req2 ready stays 0 until req1's tail is accepted; req2 head is sent the next cycle.
- Credit stall: no credit_in and req0 streams 4 flits with DEPTH=2 → exactly 2 send_out pulses, then req_ready=0. A credit_in pulse at cycle 10 → one more flit accepted at cycle 11.
- Simultaneous accept and credit with credits=1 → the count stays 1 and the next flit is accepted the following cycle. Spurious credit_in at credits=2 → credit_overflow=1 and stays 1.
- Reset mid-packet: assert rst_n low while LOCKED on req3 → immediately send_out=0 and ready all 0. After release: credits=2, IDLE, rr_ptr=0, and req0 wins over req3.
